// File: rtl/ysyx_23060072_ifu_axi_fetch_pkg.sv
// ysyx_23060072_ifu_axi_fetch_pkg
// Shared definitions for the instruction-fetch AXI4-Lite master:
//   - fetch_state_e : FSM state encoding (IDLE / AR / R / RSP)
//   - NOP_INSTR     : instruction returned on any access fault (addi x0,x0,0)
//   - RESP_OKAY     : AXI OKAY response code
//   - ENABLE/DISABLE: single-bit enable constants used across the core
//   - is_word_aligned: true when the two low PC bits are zero
package ysyx_23060072_ifu_axi_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_RSP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_23060072_ifu_last_fetch.sv
// ysyx_23060072_ifu_last_fetch
// One-entry last-fetch register {valid, pc, instr} with address compare.
// Lets a re-fetch of the most recently returned PC skip the bus.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   lookup_addr     : PC being requested by the IF stage
//   hit, hit_instr  : entry is valid and matches lookup_addr; stored word
//   update          : store update_pc/update_instr and mark valid
//   invalidate      : clear the entry (takes priority over update)
module ysyx_23060072_ifu_last_fetch
    import ysyx_23060072_ifu_axi_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [31:0]       hit_instr,
    input  logic              update,
    input  logic              invalidate,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic [31:0]       update_instr
);

    logic              valid_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= DISABLE;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (invalidate) begin
            valid_q <= DISABLE;
        end else if (update) begin
            valid_q <= ENABLE;
            pc_q    <= update_pc;
            instr_q <= update_instr;
        end
    end

    assign hit       = valid_q && (lookup_addr == pc_q);
    assign hit_instr = instr_q;

endmodule

// File: rtl/ysyx_23060072_ifu_axi_fetch.sv
// ysyx_23060072_ifu_axi_fetch
// Instruction-fetch bus master: takes one PC at a time from the IF stage,
// performs a single-beat AXI4-Lite read (AR/R only) and returns
// {instr, pc, err}. Flushes discard the outstanding fetch.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o/req_addr_i: fetch request from IF
//   flush_i                          : cancel outstanding fetch
//   rsp_valid_o/rsp_ready_i          : response handshake to IF
//   rsp_instr_o/rsp_pc_o/rsp_err_o   : response payload
//   araddr_o/arvalid_o/arready_i     : AXI AR channel
//   rdata_i/rresp_i/rvalid_i/rready_o: AXI R channel
// Optional feature: define YSYX_23060072_IFU_REFETCH_BYPASS_EN to add the
// last-fetch bypass register (ysyx_23060072_ifu_last_fetch).
module ysyx_23060072_ifu_axi_fetch
    import ysyx_23060072_ifu_axi_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              flush_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_instr_o,
    output logic [ADDR_W-1:0] rsp_pc_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [31:0]       rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic              err_q;
    logic              drop_q;

    logic              bypass_hit;
    logic [31:0]       bypass_instr;

`ifdef YSYX_23060072_IFU_REFETCH_BYPASS_EN
    logic lf_update;
    logic lf_invalidate;

    // Only a beat that is actually delivered to IF may refresh the entry;
    // any error beat (delivered or dropped) invalidates it.
    assign lf_update     = (state_q == S_R) && rvalid_i && !drop_q && !flush_i
                           && (rresp_i == RESP_OKAY);
    assign lf_invalidate = (state_q == S_R) && rvalid_i && (rresp_i != RESP_OKAY);

    ysyx_23060072_ifu_last_fetch #(
        .ADDR_W(ADDR_W)
    ) u_last_fetch (
        .clk          (clk),
        .rst          (rst),
        .lookup_addr  (req_addr_i),
        .hit          (bypass_hit),
        .hit_instr    (bypass_instr),
        .update       (lf_update),
        .invalidate   (lf_invalidate),
        .update_pc    (pc_q),
        .update_instr (rdata_i)
    );
`else
    assign bypass_hit   = DISABLE;
    assign bypass_instr = NOP_INSTR;
`endif

    // Main fetch FSM. A flush in AR/R only marks the fetch as dropped so the
    // AXI transaction still completes legally; the R beat is then thrown away.
    // A flush coinciding with the R beat drops it directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            err_q   <= DISABLE;
            drop_q  <= DISABLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    drop_q <= DISABLE;
                    if (req_valid_i) begin
                        pc_q <= req_addr_i;
                        if (!is_word_aligned(req_addr_i[1:0])) begin
                            state_q <= S_RSP;
                            instr_q <= NOP_INSTR;
                            err_q   <= ENABLE;
                        end else if (bypass_hit) begin
                            state_q <= S_RSP;
                            instr_q <= bypass_instr;
                            err_q   <= DISABLE;
                        end else begin
                            state_q <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (flush_i) begin
                        drop_q <= ENABLE;
                    end
                    if (arready_i) begin
                        state_q <= S_R;
                    end
                end
                S_R: begin
                    if (flush_i) begin
                        drop_q <= ENABLE;
                    end
                    if (rvalid_i) begin
                        if (drop_q || flush_i) begin
                            state_q <= S_IDLE;
                            drop_q  <= DISABLE;
                        end else begin
                            state_q <= S_RSP;
                            if (rresp_i == RESP_OKAY) begin
                                instr_q <= rdata_i;
                                err_q   <= DISABLE;
                            end else begin
                                instr_q <= NOP_INSTR;
                                err_q   <= ENABLE;
                            end
                        end
                    end
                end
                S_RSP: begin
                    if (flush_i || rsp_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are pure state decodes; payload comes from flops.
    assign req_ready_o = (state_q == S_IDLE);
    assign arvalid_o   = (state_q == S_AR);
    assign rready_o    = (state_q == S_R);
    assign rsp_valid_o = (state_q == S_RSP);
    assign araddr_o    = pc_q;
    assign rsp_pc_o    = pc_q;
    assign rsp_instr_o = instr_q;
    assign rsp_err_o   = err_q;

endmodule

// File: doc/ysyx_23060072_ifu_axi_fetch.md
# ysyx_23060072_ifu_axi_fetch

Instruction-fetch bus master directly upstream of the IF stage. Accepts one fetch request (a PC) at a time from the IF stage and performs a single-beat AXI4-Lite read (AR/R channels only) to instruction memory. Returns the 32-bit instruction, its PC and an error flag. Honours pipeline flushes by discarding in-flight responses.

## Interface
- ADDR_W, 32, fetch address width; data width is fixed at 32.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  IF stage presents a fetch PC.
- req_ready_o  out  1  block can accept a request; high only in IDLE.
- req_addr_i  in  ADDR_W  fetch PC.
- flush_i  in  1  control-flow redirect; cancels the outstanding fetch.
- rsp_valid_o  out  1  instruction available.
- rsp_ready_i  in  1  IF stage consumes response (low while IF is held).
- rsp_instr_o  out  32  instruction word.
- rsp_pc_o  out  ADDR_W  PC of rsp_instr_o.
- rsp_err_o  out  1  access fault (bus error or misaligned PC).
- araddr_o  out  ADDR_W  AR address.
- arvalid_o  out  1  AR valid.
- arready_i  in  1  AR ready.
- rdata_i  in  32  R data.
- rresp_i  in  2  R response; 2'b00 = OKAY.
- rvalid_i  in  1  R valid.
- rready_o  out  1  R ready; high only in R state.

## Operation
- States: IDLE, AR, R, RSP.
- **IDLE.** On req_valid_i & req_ready_o, the block latches req_addr_i into pc_q.
  - Aligned address: go to AR.
  - addr[1:0] != 0: go to RSP with rsp_err_o=1 and instr=32'h0000_0013 (NOP). No bus access.
- **AR.** arvalid_o=1 and araddr_o=pc_q, held stable until arready_i. On the handshake, go to R.
- **R.** rready_o=1. On rvalid_i, capture the response and go to RSP.
  - rresp_i==OKAY: instr=rdata_i, err=0.
  - Otherwise: instr=NOP, err=1.
- **RSP.** rsp_valid_o=1 and outputs are stable until rsp_ready_i; then go to IDLE.
- **Flush.** Sets a drop flag.
  - In AR or R, the AXI transaction still completes legally; the R beat is then discarded, no RSP is produced, and the block goes to IDLE.
  - In RSP, the response is dropped immediately and the block goes to IDLE.
  - In IDLE with req_valid_i in the same cycle, the new request is accepted and is not flushed.
  - flush_i together with rvalid_i: the beat is discarded.
- Drop flag clears on entry to IDLE.
- At most one outstanding AXI read at any time.

## Timing
- Reset values: state=IDLE, req_ready_o=1, all other outputs 0, pc_q=0, drop flag=0.
- Reset asserted mid-transaction returns the block to IDLE immediately. The memory slave shares this reset, so no orphan beat arrives.
- Minimum latency, with arready and rvalid returned in the first eligible cycle:
  - Request accepted at cycle 0, arvalid at cycle 1, rready at cycle 2, rsp_valid_o at cycle 3.
  - Peak throughput is one fetch per 4 cycles.
- Misaligned request: rsp_valid_o at cycle 1.
- All outputs are registered or decoded from state only. There is no combinational path from AXI inputs to rsp_*.

## Configuration
- Macro: YSYX_23060072_IFU_REFETCH_BYPASS_EN.
- **Defined.** A one-entry last-fetch register holds {valid, pc, instr} of the most recent OKAY response.
  - A request whose address equals the stored pc while the entry is valid skips AR/R, going IDLE to RSP with the stored instruction; rsp_valid_o at cycle 1.
  - The entry is updated on every OKAY response that is not dropped, and invalidated on any error response.
  - This serves re-fetches caused by IF holds.
- **Undefined.** Every aligned request goes to the bus; no extra flops.

## Structure
- Shared package/define file holds:
  - state encoding (IDLE/AR/R/RSP)
  - NOP constant 32'h0000_0013
  - RESP_OKAY 2'b00
  - enable/disable constants already used across the core
- Optional sub-module ysyx_23060072_ifu_last_fetch, instantiated only under the macro. It implements the bypass register and compare.

## Test plan
- Aligned fetch 0x8000_0000, arready and rvalid immediate, rdata 0x0010_0093 -> rsp_valid_o at cycle 3 with rsp_pc_o=0x8000_0000, instr 0x0010_0093, err=0.
- rsp_ready_i held low 5 cycles in RSP -> outputs stable, req_ready_o=0, no new AR; release -> IDLE next cycle.
- flush_i during AR with arready delayed 4 cycles -> arvalid held until handshake, R beat accepted and discarded, rsp_valid_o never asserted.
- rresp_i=2'b10 -> rsp_instr_o=0x0000_0013, rsp_err_o=1. Request 0x8000_0002 -> err=1 at cycle 1 with no arvalid.
- With macro: fetch 0x8000_0004 twice -> second response at cycle 1 with no AR; after an error response, the same PC goes to the bus again.
